// File: rtl/halut_decoder_ctrl.sv
// Purpose: sequencer feeding LUT contents and encoded k-indices into the halut decoder array, then collecting results.
// Latency: write/control/result outputs are registered, one cycle after the accepted beat; done/error coincide with the final result beat.
// Backpressure: lut_ready_o/enc_ready_o depend on state only; the result stream from the decoders cannot be stalled.

package halut_pkg;
    localparam int unsigned DecoderUnits  = 8;
    localparam int unsigned K             = 16;
    localparam int unsigned C             = 32;
    localparam int unsigned DataTypeWidth = 16;
endpackage

module halut_decoder_ctrl #(
    parameter int unsigned DecoderUnits   = halut_pkg::DecoderUnits,
    parameter int unsigned K              = halut_pkg::K,
    parameter int unsigned C              = halut_pkg::C,
    parameter int unsigned DataTypeWidth  = halut_pkg::DataTypeWidth,
    parameter int unsigned TimeoutCycles  = 64,
    parameter int unsigned TotalAddrWidth = $clog2(C * K),
    parameter int unsigned CAddrWidth     = $clog2(C),
    parameter int unsigned TreeDepth      = $clog2(K),
    parameter int unsigned DecAddrWidth   = $clog2(DecoderUnits)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      start_i,
    input  logic                      load_lut_i,
    input  logic                      lut_valid_i,
    output logic                      lut_ready_o,
    input  logic [DataTypeWidth-1:0]  lut_data_i,
    input  logic                      enc_valid_i,
    output logic                      enc_ready_o,
    input  logic [TreeDepth-1:0]      enc_k_i,
    output logic [DecAddrWidth-1:0]   m_addr_o,
    output logic [TotalAddrWidth-1:0] waddr_o,
    output logic [DataTypeWidth-1:0]  wdata_o,
    output logic                      we_o,
    output logic [CAddrWidth-1:0]     c_addr_o,
    output logic [TreeDepth-1:0]      k_addr_o,
    output logic                      decoder_o,
    input  logic [31:0]               result_i,
    input  logic                      valid_i,
    input  logic [DecAddrWidth-1:0]   m_addr_i,
    output logic                      res_valid_o,
    output logic [31:0]               res_data_o,
    output logic [DecAddrWidth-1:0]   res_m_addr_o,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      error_o
);

    localparam int unsigned ToWidth = $clog2(TimeoutCycles + 1);
    localparam logic [DecAddrWidth-1:0]   LastM  = DecAddrWidth'(DecoderUnits - 1);
    localparam logic [TotalAddrWidth-1:0] LastW  = TotalAddrWidth'(C * K - 1);
    localparam logic [CAddrWidth-1:0]     LastC  = CAddrWidth'(C - 1);
    localparam logic [ToWidth-1:0]        LastTo = ToWidth'(TimeoutCycles - 1);
    localparam logic [ToWidth-1:0]        MaxTo  = ToWidth'(TimeoutCycles);

    typedef enum logic [1:0] {StIdle, StLoad, StDecode, StDrain} state_e;

    state_e r_state, w_next_state;

    logic [DecAddrWidth-1:0]   r_m_cnt;
    logic [TotalAddrWidth-1:0] r_w_cnt;
    logic [CAddrWidth-1:0]     r_c_cnt;
    logic [DecAddrWidth-1:0]   r_r_cnt;
    logic [ToWidth-1:0]        r_to_cnt;

    logic w_lut_rdy, w_enc_rdy, w_busy;
    logic w_lut_acc, w_lut_last, w_enc_acc, w_enc_last;
    logic w_in_drain, w_res_match, w_res_err, w_res_done, w_timeout;

    assign w_lut_acc   = lut_valid_i & w_lut_rdy;
    assign w_lut_last  = w_lut_acc && (r_m_cnt == LastM) && (r_w_cnt == LastW);
    assign w_enc_acc   = enc_valid_i & w_enc_rdy;
    assign w_enc_last  = w_enc_acc && (r_c_cnt == LastC);
    assign w_in_drain  = (r_state == StDrain);
    assign w_res_match = (m_addr_i == r_r_cnt);
    assign w_res_err   = w_in_drain && valid_i && !w_res_match;
    assign w_res_done  = w_in_drain && valid_i && w_res_match && (r_r_cnt == LastM);
    assign w_timeout   = w_in_drain && !valid_i && (r_to_cnt == LastTo);

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= StIdle;
        else         r_state <= w_next_state;
    end

    // Next-state decode; start is only honoured in IDLE
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            StIdle:   if (start_i) w_next_state = load_lut_i ? StLoad : StDecode;
            StLoad:   if (w_lut_last) w_next_state = StDecode;
            StDecode: if (w_enc_last) w_next_state = StDrain;
            StDrain:  if (w_res_err || w_res_done || w_timeout) w_next_state = StIdle;
            default:  w_next_state = StIdle;
        endcase
    end

    // State-only handshake and status outputs
    always_comb begin
        w_lut_rdy = (r_state == StLoad);
        w_enc_rdy = (r_state == StDecode);
        w_busy    = (r_state != StIdle);
    end

    assign lut_ready_o = w_lut_rdy;
    assign enc_ready_o = w_enc_rdy;
    assign busy_o      = w_busy;

    // Job counters: cleared in IDLE so every job starts from unit 0, address 0, codebook 0
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_m_cnt  <= '0;
            r_w_cnt  <= '0;
            r_c_cnt  <= '0;
            r_r_cnt  <= '0;
            r_to_cnt <= '0;
        end else begin
            case (r_state)
                StLoad: if (w_lut_acc) begin
                    if (r_w_cnt == LastW) begin
                        r_w_cnt <= '0;
                        r_m_cnt <= (r_m_cnt == LastM) ? '0 : r_m_cnt + 1'b1;
                    end else begin
                        r_w_cnt <= r_w_cnt + 1'b1;
                    end
                end
                StDecode: if (w_enc_acc) r_c_cnt <= (r_c_cnt == LastC) ? '0 : r_c_cnt + 1'b1;
                StDrain: begin
                    if (valid_i) begin
                        r_to_cnt <= '0;
                        if (w_res_match && (r_r_cnt != LastM)) r_r_cnt <= r_r_cnt + 1'b1;
                    end else if (r_to_cnt != MaxTo) begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                default: begin
                    r_m_cnt  <= '0;
                    r_w_cnt  <= '0;
                    r_c_cnt  <= '0;
                    r_r_cnt  <= '0;
                    r_to_cnt <= '0;
                end
            endcase
        end
    end

    // Decoder write port: one write per accepted LUT beat, address/data held otherwise
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            we_o     <= 1'b0;
            m_addr_o <= '0;
            waddr_o  <= '0;
            wdata_o  <= '0;
        end else begin
            we_o <= w_lut_acc;
            if (w_lut_acc) begin
                m_addr_o <= r_m_cnt;
                waddr_o  <= r_w_cnt;
                wdata_o  <= lut_data_i;
            end
        end
    end

    // Decoder control: rises on first enc beat, held through DRAIN, dropped one cycle after the job ends
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            decoder_o <= 1'b0;
            c_addr_o  <= '0;
            k_addr_o  <= '0;
        end else if (r_state == StIdle) begin
            decoder_o <= 1'b0;
            c_addr_o  <= '0;
            k_addr_o  <= '0;
        end else if (w_enc_acc) begin
            decoder_o <= 1'b1;
            c_addr_o  <= r_c_cnt;
            k_addr_o  <= enc_k_i;
        end
    end

    // Result forwarding in every state, with completion/error flags aligned to the forwarded beat
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            res_valid_o  <= 1'b0;
            res_data_o   <= '0;
            res_m_addr_o <= '0;
            done_o       <= 1'b0;
            error_o      <= 1'b0;
        end else begin
            res_valid_o  <= valid_i;
            res_data_o   <= result_i;
            res_m_addr_o <= m_addr_i;
            done_o       <= w_res_done;
            error_o      <= w_res_err || w_timeout;
        end
    end

endmodule

// File: tb/tb_halut_decoder_ctrl.sv
// Purpose: directed bench for halut_decoder_ctrl with DecoderUnits=4, C=2, K=4.
// Latency: expects registered outputs one cycle after each accepted beat.
// Backpressure: drives valid and waits on the DUT ready, bounded per beat.

module tb_halut_decoder_ctrl;

    localparam int DU = 4;
    localparam int CB = 2;
    localparam int KP = 4;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;
    logic          start_i = 1'b0;
    logic          load_lut_i = 1'b0;
    logic          lut_valid_i = 1'b0;
    logic          lut_ready_o;
    logic [DW-1:0] lut_data_i = '0;
    logic          enc_valid_i = 1'b0;
    logic          enc_ready_o;
    logic [1:0]    enc_k_i = '0;
    logic [1:0]    m_addr_o;
    logic [2:0]    waddr_o;
    logic [DW-1:0] wdata_o;
    logic          we_o;
    logic          c_addr_o;
    logic [1:0]    k_addr_o;
    logic          decoder_o;
    logic [31:0]   result_i = '0;
    logic          valid_i = 1'b0;
    logic [1:0]    m_addr_i = '0;
    logic          res_valid_o;
    logic [31:0]   res_data_o;
    logic [1:0]    res_m_addr_o;
    logic          busy_o;
    logic          done_o;
    logic          error_o;

    int n_tests = 0;
    int n_fail  = 0;
    int mon_we = 0, mon_lrdy = 0, mon_done = 0, mon_err = 0;
    logic [1:0] ks [2];

    halut_decoder_ctrl #(
        .DecoderUnits(DU), .K(KP), .C(CB), .DataTypeWidth(DW), .TimeoutCycles(64)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .load_lut_i(load_lut_i),
        .lut_valid_i(lut_valid_i), .lut_ready_o(lut_ready_o), .lut_data_i(lut_data_i),
        .enc_valid_i(enc_valid_i), .enc_ready_o(enc_ready_o), .enc_k_i(enc_k_i),
        .m_addr_o(m_addr_o), .waddr_o(waddr_o), .wdata_o(wdata_o), .we_o(we_o),
        .c_addr_o(c_addr_o), .k_addr_o(k_addr_o), .decoder_o(decoder_o),
        .result_i(result_i), .valid_i(valid_i), .m_addr_i(m_addr_i),
        .res_valid_o(res_valid_o), .res_data_o(res_data_o), .res_m_addr_o(res_m_addr_o),
        .busy_o(busy_o), .done_o(done_o), .error_o(error_o)
    );

    always #5 clk = ~clk;

    // Event counters sampled mid-cycle
    always @(negedge clk) begin
        if (rst_ni) begin
            mon_we   += int'(we_o);
            mon_lrdy += int'(lut_ready_o);
            mon_done += int'(done_o);
            mon_err  += int'(error_o);
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_lut(input int m, input int w, input bit gaps);
        logic [DW-1:0] d;
        bit acc, rdy;
        d = DW'(16'hA000 + m * 8 + w);
        if (gaps && ($urandom_range(0, 1) == 1)) begin
            lut_valid_i = 1'b0;
            tick();
            chk("we_gap", we_o, 1'b0);
        end
        lut_valid_i = 1'b1;
        lut_data_i  = d;
        acc = 1'b0;
        for (int i = 0; i < 8 && !acc; i++) begin
            rdy = lut_ready_o;
            tick();
            if (rdy) acc = 1'b1;
        end
        lut_valid_i = 1'b0;
        chk("lut_accept", acc, 1'b1);
        chk("we", we_o, 1'b1);
        chk("we_m", m_addr_o, m);
        chk("we_waddr", waddr_o, w);
        chk("we_data", wdata_o, d);
    endtask

    task automatic send_enc(input int c, input bit gaps, input bit started);
        bit acc, rdy;
        if (gaps && ($urandom_range(0, 1) == 1)) begin
            enc_valid_i = 1'b0;
            tick();
            if (started) begin
                chk("dec_gap", decoder_o, 1'b1);
                chk("c_hold", c_addr_o, c - 1);
                chk("k_hold", k_addr_o, ks[c-1]);
            end
        end
        enc_valid_i = 1'b1;
        enc_k_i     = ks[c];
        acc = 1'b0;
        for (int i = 0; i < 8 && !acc; i++) begin
            rdy = enc_ready_o;
            tick();
            if (rdy) acc = 1'b1;
        end
        enc_valid_i = 1'b0;
        chk("enc_accept", acc, 1'b1);
        chk("decoder", decoder_o, 1'b1);
        chk("c_addr", c_addr_o, c);
        chk("k_addr", k_addr_o, ks[c]);
    endtask

    task automatic send_res(input int m);
        valid_i  = 1'b1;
        m_addr_i = 2'(m);
        result_i = 32'hC0DE_0000 + 32'(m);
        tick();
        valid_i = 1'b0;
        chk("res_valid", res_valid_o, 1'b1);
        chk("res_m", res_m_addr_o, m);
        chk("res_data", res_data_o, 32'hC0DE_0000 + 32'(m));
    endtask

    task automatic start_job(input bit load);
        start_i    = 1'b1;
        load_lut_i = load;
        tick();
        start_i    = 1'b0;
        load_lut_i = 1'b0;
        chk("busy_start", busy_o, 1'b1);
        chk("lut_rdy_start", lut_ready_o, load);
        chk("enc_rdy_start", enc_ready_o, !load);
    endtask

    task automatic run_job(input bit load, input bit gaps);
        start_job(load);
        if (load) begin
            for (int m = 0; m < DU; m++)
                for (int w = 0; w < CB * KP; w++)
                    send_lut(m, w, gaps);
            chk("enc_rdy_after_load", enc_ready_o, 1'b1);
        end
        for (int c = 0; c < CB; c++) send_enc(c, gaps, c > 0);
        chk("drain_rdy", {lut_ready_o, enc_ready_o}, 2'b00);
        for (int m = 0; m < DU; m++) begin
            send_res(m);
            chk("done_flag", done_o, m == DU - 1);
            chk("err_flag", error_o, 1'b0);
        end
        tick();
        chk("busy_after", busy_o, 1'b0);
        chk("dec_after", decoder_o, 1'b0);
        chk("done_once", done_o, 1'b0);
    endtask

    initial begin
        int base_we, base_lrdy, base_done, base_err, n;
        ks[0] = 2'd3;
        ks[1] = 2'd1;

        // Reset state
        #1;
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_we", we_o, 1'b0);
        chk("rst_dec", decoder_o, 1'b0);
        chk("rst_rdy", {lut_ready_o, enc_ready_o}, 2'b00);
        chk("rst_res", {res_valid_o, done_o, error_o}, 3'b000);
        repeat (3) tick();
        rst_ni = 1'b1;
        tick();
        chk("idle_busy", busy_o, 1'b0);

        // Full job with LUT load
        run_job(1'b1, 1'b0);

        // Reuse resident LUTs: no writes, LUT port never ready
        base_we   = mon_we;
        base_lrdy = mon_lrdy;
        run_job(1'b0, 1'b0);
        chk("noload_we", mon_we - base_we, 0);
        chk("noload_lrdy", mon_lrdy - base_lrdy, 0);

        // Random valid gaps on both input streams
        run_job(1'b1, 1'b1);

        // Out-of-order result
        base_done = mon_done;
        start_job(1'b0);
        for (int c = 0; c < CB; c++) send_enc(c, 1'b0, c > 0);
        send_res(0);
        chk("order_err0", error_o, 1'b0);
        send_res(2);
        chk("order_err", error_o, 1'b1);
        chk("order_done", done_o, 1'b0);
        chk("order_busy", busy_o, 1'b0);
        tick();
        chk("order_dec", decoder_o, 1'b0);
        chk("order_nodone", mon_done - base_done, 0);

        // Timeout in DRAIN
        base_err = mon_err;
        start_job(1'b0);
        for (int c = 0; c < CB; c++) send_enc(c, 1'b0, c > 0);
        n = 0;
        for (int i = 1; i <= 100 && n == 0; i++) begin
            tick();
            if (error_o) n = i;
        end
        chk("to_cycles", n, 64);
        chk("to_dec_hold", decoder_o, 1'b1);
        tick();
        chk("to_dec_fall", decoder_o, 1'b0);
        chk("to_busy", busy_o, 1'b0);
        repeat (3) tick();
        chk("to_err_once", mon_err - base_err, 1);

        // Reset mid-LOAD after 10 beats, then restart
        start_job(1'b1);
        for (int b = 0; b < 10; b++) send_lut(b / 8, b % 8, 1'b0);
        rst_ni = 1'b0;
        #1;
        chk("mid_rst_we", we_o, 1'b0);
        chk("mid_rst_busy", busy_o, 1'b0);
        chk("mid_rst_addr", {m_addr_o, waddr_o}, 5'd0);
        chk("mid_rst_ctl", {decoder_o, lut_ready_o, enc_ready_o, res_valid_o}, 4'd0);
        repeat (2) tick();
        chk("mid_rst_hold", {we_o, busy_o, done_o, error_o}, 4'd0);
        rst_ni = 1'b1;
        tick();
        run_job(1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "bench time limit");
    end

endmodule
